// File: rtl/exc_ctrl.sv
// Exception/interrupt controller: invalid-opcode, IRQ and ERET handling with fetch redirect.
// Latency: redirect is combinational, so the PC lands on the target one edge after the trigger; ELR/ESR/state update on that edge.
// Backpressure: none; double fault freezes the PC through a self-redirect until reset.
module exc_ctrl #(
    parameter logic [63:0] VECTOR_BASE = 64'h0000_0000_0000_00D8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] PC_F,
    input  logic [63:0] NextPC_F,
    input  logic        InvOp_D,
    input  logic        Eret_D,
    input  logic        Irq,
    output logic        EProc_F,
    output logic [63:0] EVAddr_F,
    output logic        Squash_W,
    output logic [63:0] Exc_ELR,
    output logic [3:0]  Exc_ESR,
    output logic        InHandler,
    output logic        Halt
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HANDLER = 2'd1,
        S_HALT    = 2'd2
    } state_t;

    localparam logic [3:0] ESR_IRQ    = 4'b0001;
    localparam logic [3:0] ESR_INVOP  = 4'b0010;
    localparam logic [3:0] ESR_ERET   = 4'b0100;
    localparam logic [3:0] ESR_DOUBLE = 4'b1000;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [63:0] r_elr;
    logic [63:0] w_elr_nxt;
    logic [3:0]  r_esr;
    logic [3:0]  w_esr_nxt;
    logic        r_irq_pend;
    logic        w_irq_pend_nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_elr      <= 64'd0;
            r_esr      <= 4'd0;
            r_irq_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_elr      <= w_elr_nxt;
            r_esr      <= w_esr_nxt;
            r_irq_pend <= w_irq_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_elr_nxt      = r_elr;
        w_esr_nxt      = r_esr;
        w_irq_pend_nxt = r_irq_pend;
        EProc_F        = 1'b0;
        EVAddr_F       = VECTOR_BASE;
        Squash_W       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (InvOp_D) begin
                    EProc_F        = 1'b1;
                    Squash_W       = 1'b1;
                    w_esr_nxt      = ESR_INVOP;
                    w_elr_nxt      = PC_F;
                    w_irq_pend_nxt = r_irq_pend | Irq;
                    w_state_nxt    = S_HANDLER;
                end else if (Eret_D) begin
                    EProc_F        = 1'b1;
                    Squash_W       = 1'b1;
                    w_esr_nxt      = ESR_ERET;
                    w_elr_nxt      = PC_F;
                    w_irq_pend_nxt = r_irq_pend | Irq;
                    w_state_nxt    = S_HANDLER;
                end else if (Irq || r_irq_pend) begin
                    // The interrupted instruction retires, so return resumes after it.
                    EProc_F        = 1'b1;
                    w_esr_nxt      = ESR_IRQ;
                    w_elr_nxt      = NextPC_F;
                    w_irq_pend_nxt = 1'b0;
                    w_state_nxt    = S_HANDLER;
                end
            end
            S_HANDLER: begin
                w_irq_pend_nxt = r_irq_pend | Irq;
                if (InvOp_D) begin
                    Squash_W    = 1'b1;
                    w_esr_nxt   = r_esr | ESR_DOUBLE;
                    w_state_nxt = S_HALT;
                end else if (Eret_D) begin
                    EProc_F     = 1'b1;
                    EVAddr_F    = r_elr;
                    w_state_nxt = S_IDLE;
                end
            end
            S_HALT: begin
                // Redirecting to the current PC holds fetch in place.
                EProc_F  = 1'b1;
                EVAddr_F = PC_F;
                Squash_W = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign Exc_ELR   = r_elr;
    assign Exc_ESR   = r_esr;
    assign InHandler = (r_state == S_HANDLER);
    assign Halt      = (r_state == S_HALT);

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: entry/exit, priority, pending IRQ replay, double fault, async reset.
module tb_exc_ctrl;

    logic        clk;
    logic        reset;
    logic [63:0] PC_F;
    logic [63:0] NextPC_F;
    logic        InvOp_D;
    logic        Eret_D;
    logic        Irq;
    logic        EProc_F;
    logic [63:0] EVAddr_F;
    logic        Squash_W;
    logic [63:0] Exc_ELR;
    logic [3:0]  Exc_ESR;
    logic        InHandler;
    logic        Halt;

    int checks;
    int failures;

    exc_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .PC_F      (PC_F),
        .NextPC_F  (NextPC_F),
        .InvOp_D   (InvOp_D),
        .Eret_D    (Eret_D),
        .Irq       (Irq),
        .EProc_F   (EProc_F),
        .EVAddr_F  (EVAddr_F),
        .Squash_W  (Squash_W),
        .Exc_ELR   (Exc_ELR),
        .Exc_ESR   (Exc_ESR),
        .InHandler (InHandler),
        .Halt      (Halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then give the new state 1ns to settle before driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] pc, input logic [63:0] npc,
                         input logic inv, input logic eret, input logic irq);
        PC_F     = pc;
        NextPC_F = npc;
        InvOp_D  = inv;
        Eret_D   = eret;
        Irq      = irq;
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        PC_F     = 64'd0;
        NextPC_F = 64'd0;
        InvOp_D  = 1'b0;
        Eret_D   = 1'b0;
        Irq      = 1'b0;
        #12;
        chk("rst_eproc",  {63'd0, EProc_F},   64'd0);
        chk("rst_evaddr", EVAddr_F,           64'hD8);
        chk("rst_squash", {63'd0, Squash_W},  64'd0);
        chk("rst_elr",    Exc_ELR,            64'd0);
        chk("rst_esr",    {60'd0, Exc_ESR},   64'd0);
        chk("rst_inh",    {63'd0, InHandler}, 64'd0);
        chk("rst_halt",   {63'd0, Halt},      64'd0);
        reset = 1'b0;
        tick();

        // Invalid opcode in IDLE
        drive(64'h40, 64'h44, 1, 0, 0);
        chk("inv_eproc",  {63'd0, EProc_F},  64'd1);
        chk("inv_evaddr", EVAddr_F,          64'hD8);
        chk("inv_squash", {63'd0, Squash_W}, 64'd1);
        tick();
        drive(64'hD8, 64'hDC, 0, 0, 0);
        chk("inv_elr",   Exc_ELR,            64'h40);
        chk("inv_esr",   {60'd0, Exc_ESR},   64'h2);
        chk("inv_inh",   {63'd0, InHandler}, 64'd1);
        chk("inv_idle_eproc", {63'd0, EProc_F}, 64'd0);
        drive(64'hDC, 64'hE0, 0, 1, 0);
        chk("inv_eret_eproc",  {63'd0, EProc_F},  64'd1);
        chk("inv_eret_evaddr", EVAddr_F,          64'h40);
        chk("inv_eret_squash", {63'd0, Squash_W}, 64'd0);
        tick();
        drive(64'h40, 64'h44, 0, 0, 0);
        chk("inv_ret_inh", {63'd0, InHandler}, 64'd0);
        chk("inv_ret_elr", Exc_ELR,            64'h40);
        chk("inv_ret_eproc", {63'd0, EProc_F}, 64'd0);

        // External interrupt in IDLE
        drive(64'h100, 64'h104, 0, 0, 1);
        chk("irq_eproc",  {63'd0, EProc_F},  64'd1);
        chk("irq_evaddr", EVAddr_F,          64'hD8);
        chk("irq_squash", {63'd0, Squash_W}, 64'd0);
        tick();
        drive(64'hD8, 64'hDC, 0, 0, 0);
        chk("irq_elr", Exc_ELR,            64'h104);
        chk("irq_esr", {60'd0, Exc_ESR},   64'h1);
        chk("irq_inh", {63'd0, InHandler}, 64'd1);
        drive(64'hDC, 64'hE0, 0, 1, 0);
        chk("irq_eret_eproc",  {63'd0, EProc_F}, 64'd1);
        chk("irq_eret_evaddr", EVAddr_F,         64'h104);
        tick();
        drive(64'h104, 64'h108, 0, 0, 0);
        chk("irq_ret_inh",   {63'd0, InHandler}, 64'd0);
        chk("irq_ret_eproc", {63'd0, EProc_F},   64'd0);

        // IRQ pulse while in handler is replayed after ERET
        drive(64'h1FC, 64'h200, 0, 0, 1);
        tick();
        drive(64'hD8, 64'hDC, 0, 0, 1);
        chk("pend_masked", {63'd0, EProc_F}, 64'd0);
        chk("pend_elr0",   Exc_ELR,          64'h200);
        tick();
        drive(64'hDC, 64'hE0, 0, 1, 0);
        chk("pend_eret_evaddr", EVAddr_F, 64'h200);
        tick();
        drive(64'h200, 64'h204, 0, 0, 0);
        chk("pend_reenter_eproc",  {63'd0, EProc_F},  64'd1);
        chk("pend_reenter_squash", {63'd0, Squash_W}, 64'd0);
        tick();
        drive(64'hD8, 64'hDC, 0, 0, 0);
        chk("pend_elr", Exc_ELR,            64'h204);
        chk("pend_esr", {60'd0, Exc_ESR},   64'h1);
        chk("pend_inh", {63'd0, InHandler}, 64'd1);
        drive(64'hDC, 64'hE0, 0, 1, 0);
        tick();
        drive(64'h204, 64'h208, 0, 0, 0);
        chk("pend_cleared", {63'd0, EProc_F}, 64'd0);

        // InvOp and Irq together: InvOp wins, Irq becomes pending
        drive(64'h300, 64'h304, 1, 0, 1);
        chk("prio_squash", {63'd0, Squash_W}, 64'd1);
        tick();
        drive(64'hD8, 64'hDC, 0, 0, 1);
        chk("prio_elr", Exc_ELR,          64'h300);
        chk("prio_esr", {60'd0, Exc_ESR}, 64'h2);
        tick();
        drive(64'hDC, 64'hE0, 0, 1, 0);
        chk("prio_eret_evaddr", EVAddr_F, 64'h300);
        tick();
        drive(64'h300, 64'h304, 0, 0, 0);
        chk("prio_pend_eproc", {63'd0, EProc_F}, 64'd1);
        tick();
        drive(64'hD8, 64'hDC, 0, 0, 0);
        chk("prio_pend_esr", {60'd0, Exc_ESR}, 64'h1);
        chk("prio_pend_elr", Exc_ELR,          64'h304);

        // Double fault from handler with ESR=0001
        drive(64'h500, 64'h504, 1, 0, 0);
        chk("df_eproc",  {63'd0, EProc_F},  64'd0);
        chk("df_squash", {63'd0, Squash_W}, 64'd1);
        tick();
        drive(64'h600, 64'h604, 0, 0, 0);
        chk("df_halt",   {63'd0, Halt},      64'd1);
        chk("df_esr",    {60'd0, Exc_ESR},   64'h9);
        chk("df_elr",    Exc_ELR,            64'h304);
        chk("df_inh",    {63'd0, InHandler}, 64'd0);
        chk("df_eproc1", {63'd0, EProc_F},   64'd1);
        chk("df_evaddr", EVAddr_F,           64'h600);
        chk("df_squash1", {63'd0, Squash_W}, 64'd1);
        drive(64'h608, 64'h60C, 1, 1, 1);
        tick();
        drive(64'h610, 64'h614, 0, 0, 0);
        chk("df_stay_halt", {63'd0, Halt},    64'd1);
        chk("df_stay_esr",  {60'd0, Exc_ESR}, 64'h9);
        chk("df_track_pc",  EVAddr_F,         64'h610);

        reset = 1'b1;
        #1;
        chk("halt_rst", {63'd0, Halt}, 64'd0);
        reset = 1'b0;
        tick();

        // Async reset mid-handler, with an IRQ pending
        drive(64'h700, 64'h704, 1, 0, 0);
        tick();
        drive(64'hD8, 64'hDC, 0, 0, 1);
        tick();
        drive(64'hDC, 64'hE0, 0, 0, 0);
        chk("ar_pre_inh", {63'd0, InHandler}, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_inh",    {63'd0, InHandler}, 64'd0);
        chk("ar_elr",    Exc_ELR,            64'd0);
        chk("ar_esr",    {60'd0, Exc_ESR},   64'd0);
        chk("ar_evaddr", EVAddr_F,           64'hD8);
        reset = 1'b0;
        tick();
        drive(64'h800, 64'h804, 0, 0, 0);
        chk("ar_pend_cleared", {63'd0, EProc_F}, 64'd0);
        drive(64'h800, 64'h804, 0, 0, 1);
        chk("ar_irq_eproc", {63'd0, EProc_F}, 64'd1);
        tick();
        drive(64'hD8, 64'hDC, 0, 0, 0);
        chk("ar_irq_elr", Exc_ELR,            64'h804);
        chk("ar_irq_esr", {60'd0, Exc_ESR},   64'h1);
        chk("ar_irq_inh", {63'd0, InHandler}, 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
